// File: rtl/game_fsm_gen.sv
// game_fsm_gen: play/wait/game/score screen FSM with tick timer, button geometry and colour mux
module game_fsm_gen #(
  parameter int RGB_W      = 12,
  parameter int TIMER_W    = 8,
  parameter int GAME_TICKS = 60,
  parameter int TICK_DIV   = 65000000,
  parameter int BTN_X      = 380,
  parameter int BTN_Y      = 186,
  parameter int BTN_W      = 300,
  parameter int BTN_H      = 100
) (
  input  logic               pclk,
  input  logic               rst_d,
  input  logic               rect_clicked_play,
  input  logic               uart_start,
  input  logic               mouse_clicked_stop,
  input  logic [RGB_W-1:0]   rgb_in_play,
  input  logic [RGB_W-1:0]   rgb_in_wait,
  input  logic [RGB_W-1:0]   rgb_in_game,
  input  logic [RGB_W-1:0]   rgb_in_score,
  output logic [RGB_W-1:0]   rgb_out_rc,
  output logic [1:0]         state,
  output logic [10:0]        hstart_click_play,
  output logic [10:0]        vstart_click_play,
  output logic [10:0]        hlength_click_play,
  output logic [10:0]        vlength_click_play,
  output logic [TIMER_W-1:0] time_left,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, GAME = 2'b10, SCORE = 2'b11} state_t;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] TLOAD = TIMER_W'(GAME_TICKS);
  state_t state_q, state_d;
  logic [TIMER_W-1:0] time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic go_q, go_d;
  logic play_prev_q, stop_prev_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [10:0] hs_q, vs_q, hl_q, vl_q;
  logic play_ev, stop_ev, tick, idle_d;
  assign play_ev = rect_clicked_play & ~play_prev_q;
  assign stop_ev = mouse_clicked_stop & ~stop_prev_q;
  assign tick    = presc_q == PMAX;
  assign idle_d  = state_d == IDLE;
  // Next state, timer and prescaler; expiry outranks a stop event in GAME
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    go_d    = 1'b0;
    case (state_q)
      IDLE: state_d = play_ev ? WAIT : IDLE;
      WAIT: begin
        if (stop_ev) state_d = IDLE;
        else if (uart_start) begin
          state_d = GAME;
          time_d  = TLOAD;
          presc_d = '0;
        end
      end
      GAME: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && time_q == TIMER_W'(1)) begin
          state_d = SCORE;
          time_d  = '0;
          go_d    = 1'b1;
        end else if (stop_ev) state_d = IDLE;
        else if (tick && time_q != '0) time_d = time_q - TIMER_W'(1);
      end
      default: state_d = stop_ev ? IDLE : SCORE;
    endcase
  end
  // Colour source follows the state held before this edge
  always_comb begin
    rgb_d = state_q == IDLE ? rgb_in_play :
            state_q == WAIT ? rgb_in_wait :
            state_q == GAME ? rgb_in_game : rgb_in_score;
  end
  // State registers; click history resets high so a held button is not an event
  always_ff @(posedge pclk) begin
    if (rst_d) begin
      state_q     <= IDLE;
      time_q      <= '0;
      presc_q     <= '0;
      go_q        <= 1'b0;
      rgb_q       <= '0;
      play_prev_q <= 1'b1;
      stop_prev_q <= 1'b1;
      hs_q        <= 11'(BTN_X);
      vs_q        <= 11'(BTN_Y);
      hl_q        <= 11'(BTN_W);
      vl_q        <= 11'(BTN_H);
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      presc_q     <= presc_d;
      go_q        <= go_d;
      rgb_q       <= rgb_d;
      play_prev_q <= rect_clicked_play;
      stop_prev_q <= mouse_clicked_stop;
      hs_q        <= idle_d ? 11'(BTN_X) : '0;
      vs_q        <= idle_d ? 11'(BTN_Y) : '0;
      hl_q        <= idle_d ? 11'(BTN_W) : '0;
      vl_q        <= idle_d ? 11'(BTN_H) : '0;
    end
  end
  assign state              = state_q;
  assign time_left          = time_q;
  assign game_over          = go_q;
  assign rgb_out_rc         = rgb_q;
  assign hstart_click_play  = hs_q;
  assign vstart_click_play  = vs_q;
  assign hlength_click_play = hl_q;
  assign vlength_click_play = vl_q;
endmodule

// File: tb/tb_game_fsm_gen.sv
// tb_game_fsm_gen: scoreboard bench for game_fsm_gen with TICK_DIV=4, GAME_TICKS=3
module tb_game_fsm_gen;
  logic pclk, rst_d, play, uart, stop;
  logic [11:0] rgb_out;
  logic [1:0] st;
  logic [10:0] hs, vs, hl, vl;
  logic [7:0] tl;
  logic go;
  int cyc_cnt = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    string nm;
    logic [1:0] st;
    logic [7:0] tl;
    logic go;
    logic geo;
    logic crgb;
    logic [11:0] rgb;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tl_tab[12] = '{3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0};
  game_fsm_gen #(.TICK_DIV(4), .GAME_TICKS(3)) dut (
    .pclk(pclk), .rst_d(rst_d), .rect_clicked_play(play), .uart_start(uart),
    .mouse_clicked_stop(stop), .rgb_in_play(12'h111), .rgb_in_wait(12'h222),
    .rgb_in_game(12'h333), .rgb_in_score(12'h444), .rgb_out_rc(rgb_out), .state(st),
    .hstart_click_play(hs), .vstart_click_play(vs), .hlength_click_play(hl),
    .vlength_click_play(vl), .time_left(tl), .game_over(go)
  );
  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end
  always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;
  // Monitor: pop every expectation due at this cycle and compare
  always @(negedge pclk) begin
    while (q.size() != 0 && q[0].cyc <= cyc_cnt) begin
      logic bad;
      logic [43:0] g, gw;
      e = q.pop_front();
      bad = 0;
      g = {hs, vs, hl, vl};
      gw = e.geo ? {11'd380, 11'd186, 11'd300, 11'd100} : 44'd0;
      checks++;
      if (st !== e.st) begin $display("FAIL %s state got %0d want %0d", e.nm, st, e.st); bad = 1; end
      if (tl !== e.tl) begin $display("FAIL %s time_left got %0d want %0d", e.nm, tl, e.tl); bad = 1; end
      if (go !== e.go) begin $display("FAIL %s game_over got %0d want %0d", e.nm, go, e.go); bad = 1; end
      if (g !== gw) begin $display("FAIL %s geometry got %h want %h", e.nm, g, gw); bad = 1; end
      if (e.crgb && rgb_out !== e.rgb) begin $display("FAIL %s rgb got %h want %h", e.nm, rgb_out, e.rgb); bad = 1; end
      if (bad) errors++;
    end
  end
  task automatic push(string nm, logic [1:0] s, logic [7:0] t, logic g, logic geo, logic crgb = 0, logic [11:0] rgb = 0);
    exp_t x;
    x.cyc = cyc_cnt + 1; x.nm = nm; x.st = s; x.tl = t; x.go = g; x.geo = geo; x.crgb = crgb; x.rgb = rgb;
    q.push_back(x);
  endtask
  task automatic tick();
    @(negedge pclk);
  endtask
  task automatic enter_game(logic [7:0] prev_tl);
    play = 1; push("play_to_wait", 2'b01, prev_tl, 0, 0, 1, 12'h111); tick();
    play = 0; uart = 1; push("wait_to_game", 2'b10, 8'd3, 0, 0, 1, 12'h222); tick();
    uart = 0;
  endtask
  task automatic run_game(int n);
    for (int k = 1; k <= n; k++) begin
      push("game_run", 2'b10, 8'(tl_tab[k-1]), 0, 0, k == 1, 12'h333);
      tick();
    end
  endtask
  initial begin
    rst_d = 1; play = 1; uart = 0; stop = 0;
    tick();
    push("reset", 2'b00, 0, 0, 1, 1, 12'h000); tick();
    rst_d = 0;
    push("held_through_reset", 2'b00, 0, 0, 1, 1, 12'h111); tick();
    play = 0; push("idle_quiet", 2'b00, 0, 0, 1); tick();
    play = 1; push("play_event", 2'b01, 0, 0, 0, 1, 12'h111); tick();
    for (int i = 0; i < 10; i++) begin
      push("play_held", 2'b01, 0, 0, 0, 1, 12'h222); tick();
    end
    play = 0; uart = 1; push("uart_start", 2'b10, 8'd3, 0, 0, 1, 12'h222); tick();
    uart = 0;
    run_game(11);
    push("expiry", 2'b11, 0, 1, 0, 1, 12'h333); tick();
    push("score_pulse_end", 2'b11, 0, 0, 0, 1, 12'h444); tick();
    stop = 1; push("score_stop", 2'b00, 0, 0, 1, 1, 12'h444); tick();
    stop = 0; push("idle_after_score", 2'b00, 0, 0, 1, 1, 12'h111); tick();
    enter_game(8'd0);
    run_game(5);
    stop = 1; push("game_stop", 2'b00, 8'd2, 0, 1, 1, 12'h333); tick();
    stop = 0;
    for (int i = 0; i < 3; i++) begin
      push("idle_hold_time", 2'b00, 8'd2, 0, 1); tick();
    end
    enter_game(8'd2);
    run_game(11);
    stop = 1; push("stop_on_expiry", 2'b11, 0, 1, 0); tick();
    stop = 0; push("score_after_tie", 2'b11, 0, 0, 0); tick();
    stop = 1; push("score_exit", 2'b00, 0, 0, 1); tick();
    stop = 0; push("idle_again", 2'b00, 0, 0, 1); tick();
    enter_game(8'd0);
    run_game(4);
    rst_d = 1; push("reset_mid_game", 2'b00, 0, 0, 1, 1, 12'h000); tick();
    rst_d = 0; push("after_reset", 2'b00, 0, 0, 1, 1, 12'h111); tick();
    play = 1; push("wait_again", 2'b01, 0, 0, 0); tick();
    play = 0; stop = 1; uart = 1; push("wait_stop_priority", 2'b00, 0, 0, 1); tick();
    stop = 0; uart = 0; push("idle_final", 2'b00, 0, 0, 1); tick();
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
